// File: rtl/y86_pkg.sv
// ---------------------------------------------------------------------
// y86_pkg: shared Y86-64 constants (register ids, icodes) and types
// Rev 1.0
// ---------------------------------------------------------------------
`default_nettype none

package y86_pkg;

  typedef logic [3:0] reg_id_t;

  localparam reg_id_t RNONE = 4'hF;

  localparam reg_id_t RAX = 4'h0;
  localparam reg_id_t RCX = 4'h1;
  localparam reg_id_t RDX = 4'h2;
  localparam reg_id_t RBX = 4'h3;
  localparam reg_id_t RSP = 4'h4;
  localparam reg_id_t RBP = 4'h5;
  localparam reg_id_t RSI = 4'h6;
  localparam reg_id_t RDI = 4'h7;
  localparam reg_id_t R8  = 4'h8;
  localparam reg_id_t R9  = 4'h9;
  localparam reg_id_t R10 = 4'hA;
  localparam reg_id_t R11 = 4'hB;
  localparam reg_id_t R12 = 4'hC;
  localparam reg_id_t R13 = 4'hD;
  localparam reg_id_t R14 = 4'hE;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

endpackage

`default_nettype wire

// File: rtl/y86_pend_ctr.sv
// ---------------------------------------------------------------------
// y86_pend_ctr: saturating pending-write counter, +1 reserve / -0..2 release
// Rev 1.0
// ---------------------------------------------------------------------
`default_nettype none

module y86_pend_ctr
  import y86_pkg::*;
#(
  parameter int PEND_W = 2
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              inc,
  input  logic [1:0]        dec_cnt,
  output logic [PEND_W-1:0] count,
  output logic              full,
  output logic              underflow
);

  localparam int SW = PEND_W + 2;

  logic [SW-1:0]     sum;
  logic [SW-1:0]     need;
  logic [PEND_W-1:0] count_nxt;

  assign full = &count;

  // Increment is masked at saturation so the counter can never wrap.
  assign sum       = SW'(count) + SW'(inc && !full);
  assign need      = SW'(dec_cnt);
  assign underflow = (need > sum);
  assign count_nxt = underflow ? '0 : PEND_W'(sum - need);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else begin
      count <= count_nxt;
    end
  end

endmodule

`default_nettype wire

// File: rtl/y86_regfile_sb.sv
// ---------------------------------------------------------------------
// y86_regfile_sb: Y86 register file, 2R/2W, per-register RAW scoreboard
// Optional macro REGFILE_BYPASS_EN: forward same-cycle writeback. Rev 1.0
// ---------------------------------------------------------------------
`default_nettype none

module y86_regfile_sb
  import y86_pkg::*;
#(
  parameter int DATA_W   = 64,
  parameter int NUM_REGS = 15,
  parameter int ID_W     = 4,
  parameter int SP_IDX   = int'(RSP),
  parameter int SP_INIT  = 1000,
  parameter int PEND_W   = 2
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic [ID_W-1:0]            src_a,
  input  logic [ID_W-1:0]            src_b,
  output logic [DATA_W-1:0]          val_a,
  output logic [DATA_W-1:0]          val_b,
  output logic                       busy_a,
  output logic                       busy_b,
  input  logic                       rsv_valid,
  input  logic [ID_W-1:0]            rsv_id,
  output logic                       rsv_ready,
  input  logic                       wen_e,
  input  logic [ID_W-1:0]            dst_e,
  input  logic [DATA_W-1:0]          val_e,
  input  logic                       wen_m,
  input  logic [ID_W-1:0]            dst_m,
  input  logic [DATA_W-1:0]          val_m,
  output logic                       wb_err,
  output logic [NUM_REGS*DATA_W-1:0] reg_dump
);

  // The all-ones id is "no register" at any id width.
  localparam logic [ID_W-1:0] ID_NONE = {ID_W{1'b1}};
  localparam int              CW      = PEND_W + 2;

  logic [DATA_W-1:0]   regs  [NUM_REGS];
  logic [PEND_W-1:0]   cnt   [NUM_REGS];
  logic [1:0]          dec   [NUM_REGS];
  logic [NUM_REGS-1:0] inc;
  logic [NUM_REGS-1:0] full;
  logic [NUM_REGS-1:0] underflow;

  always_comb begin
    rsv_ready = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rsv_valid && (rsv_id == ID_W'(i)) && (ID_W'(i) != ID_NONE)) begin
        rsv_ready = !full[i];
      end
    end
  end

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
    localparam logic [ID_W-1:0]   IDX     = ID_W'(i);
    localparam logic [DATA_W-1:0] RST_VAL = (i == SP_IDX) ? DATA_W'(SP_INIT) : '0;

    logic              hit_e;
    logic              hit_m;
    logic [DATA_W-1:0] q;

    assign hit_e = wen_e && (dst_e == IDX) && (IDX != ID_NONE);
    assign hit_m = wen_m && (dst_m == IDX) && (IDX != ID_NONE);

    assign inc[i] = rsv_ready && (rsv_id == IDX);
    assign dec[i] = {1'b0, hit_e} + {1'b0, hit_m};

    // M outranks E on a shared destination (popq %rsp).
    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        q <= RST_VAL;
      end else if (hit_m) begin
        q <= val_m;
      end else if (hit_e) begin
        q <= val_e;
      end
    end

    assign regs[i] = q;
    assign reg_dump[i*DATA_W +: DATA_W] = q;

    y86_pend_ctr #(
      .PEND_W (PEND_W)
    ) u_ctr (
      .clock     (clock),
      .reset_n   (reset_n),
      .inc       (inc[i]),
      .dec_cnt   (dec[i]),
      .count     (cnt[i]),
      .full      (full[i]),
      .underflow (underflow[i])
    );
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wb_err <= 1'b0;
    end else if (|underflow) begin
      wb_err <= 1'b1;
    end
  end

  function automatic logic [DATA_W-1:0] rd_data(input logic [ID_W-1:0] src);
    logic [DATA_W-1:0] v;
    v = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if ((src == ID_W'(i)) && (ID_W'(i) != ID_NONE)) begin
`ifdef REGFILE_BYPASS_EN
        if (wen_m && (dst_m == src)) begin
          v = val_m;
        end else if (wen_e && (dst_e == src)) begin
          v = val_e;
        end else begin
          v = regs[i];
        end
`else
        v = regs[i];
`endif
      end
    end
    return v;
  endfunction

  function automatic logic rd_busy(input logic [ID_W-1:0] src);
    logic b;
    b = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if ((src == ID_W'(i)) && (ID_W'(i) != ID_NONE)) begin
`ifdef REGFILE_BYPASS_EN
        // Still busy only if more writes are pending than retire this cycle.
        b = (CW'(cnt[i]) > CW'(dec[i]));
`else
        b = (cnt[i] != '0);
`endif
      end
    end
    return b;
  endfunction

  always_comb begin
    val_a  = rd_data(src_a);
    val_b  = rd_data(src_b);
    busy_a = rd_busy(src_a);
    busy_b = rd_busy(src_b);
  end

endmodule

`default_nettype wire

// File: tb/tb_y86_regfile_sb.sv
// ---------------------------------------------------------------------
// tb_y86_regfile_sb: directed bench with a cycle-level reference model
// Rev 1.0
// ---------------------------------------------------------------------
`default_nettype none

module tb_y86_regfile_sb;

  localparam int DW = 64;
  localparam int NR = 15;

  logic           clock = 1'b0;
  logic           reset_n;
  logic [3:0]     src_a, src_b, rsv_id, dst_e, dst_m;
  logic           rsv_valid, wen_e, wen_m;
  logic [DW-1:0]  val_e, val_m;
  logic [DW-1:0]  val_a, val_b;
  logic           busy_a, busy_b, rsv_ready, wb_err;
  logic [NR*DW-1:0] reg_dump;
  logic [NR*DW-1:0] snap;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] m_reg [NR];
  int            m_cnt [NR];
  logic          m_err;

  always #5 clock = ~clock;

  y86_regfile_sb dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .src_a     (src_a),
    .src_b     (src_b),
    .val_a     (val_a),
    .val_b     (val_b),
    .busy_a    (busy_a),
    .busy_b    (busy_b),
    .rsv_valid (rsv_valid),
    .rsv_id    (rsv_id),
    .rsv_ready (rsv_ready),
    .wen_e     (wen_e),
    .dst_e     (dst_e),
    .val_e     (val_e),
    .wen_m     (wen_m),
    .dst_m     (dst_m),
    .val_m     (val_m),
    .wb_err    (wb_err),
    .reg_dump  (reg_dump)
  );

  task automatic chk(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: architectural state plus pending counts as plain ints.
  function automatic logic [DW-1:0] exp_val(input logic [3:0] s);
    if (s >= NR) return '0;
`ifdef REGFILE_BYPASS_EN
    if (wen_m && dst_m == s) return val_m;
    if (wen_e && dst_e == s) return val_e;
`endif
    return m_reg[s];
  endfunction

  function automatic logic exp_busy(input logic [3:0] s);
    int c;
    if (s >= NR) return 1'b0;
    c = m_cnt[s];
`ifdef REGFILE_BYPASS_EN
    if (wen_e && dst_e == s) c = c - 1;
    if (wen_m && dst_m == s) c = c - 1;
`endif
    return c > 0;
  endfunction

  function automatic logic exp_ready();
    if (!rsv_valid || rsv_id >= NR) return 1'b0;
    return m_cnt[rsv_id] < 3;
  endfunction

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NR; i++) begin
        m_reg[i] = (i == 4) ? 64'd1000 : 64'd0;
        m_cnt[i] = 0;
      end
      m_err = 1'b0;
    end else begin
      logic acc;
      acc = exp_ready();
      for (int i = 0; i < NR; i++) begin
        int d;
        d = m_cnt[i];
        if (acc && rsv_id == i) d = d + 1;
        if (wen_e && dst_e == i) d = d - 1;
        if (wen_m && dst_m == i) d = d - 1;
        if (d < 0) begin
          d = 0;
          m_err = 1'b1;
        end
        m_cnt[i] = d;
      end
      if (wen_e && dst_e < NR) m_reg[dst_e] = val_e;
      if (wen_m && dst_m < NR) m_reg[dst_m] = val_m;
    end
  end

  always @(negedge clock) begin
    chk("cmp_val_a", val_a, exp_val(src_a));
    chk("cmp_val_b", val_b, exp_val(src_b));
    chk("cmp_busy_a", busy_a, exp_busy(src_a));
    chk("cmp_busy_b", busy_b, exp_busy(src_b));
    chk("cmp_rsv_ready", rsv_ready, exp_ready());
    chk("cmp_wb_err", wb_err, m_err);
    for (int i = 0; i < NR; i++) chk("cmp_dump", reg_dump[i*DW +: DW], m_reg[i]);
  end

  task automatic idle();
    src_a = 4'd0; src_b = 4'd0;
    rsv_valid = 1'b0; rsv_id = 4'd0;
    wen_e = 1'b0; dst_e = 4'd0; val_e = '0;
    wen_m = 1'b0; dst_m = 4'd0; val_m = '0;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    logic ok;
    reset_n = 1'b0;
    idle();
    repeat (3) tick();
    chk("rst_sp_held", reg_dump[4*DW +: DW], 64'd1000);
    reset_n = 1'b1;
    #1;
    ok = 1'b1;
    for (int i = 0; i < NR; i++)
      if (reg_dump[i*DW +: DW] !== ((i == 4) ? 64'd1000 : 64'd0)) ok = 1'b0;
    chk("rst_dump_pattern", ok, 1'b1);
    chk("rst_busy_a", busy_a, 1'b0);
    chk("rst_busy_b", busy_b, 1'b0);
    chk("rst_wb_err", wb_err, 1'b0);
    src_b = 4'd4;
    #1 chk("rd_sp_val_b", val_b, 64'd1000);
    tick();

    // M beats E on the same destination
    rsv_valid = 1'b1; rsv_id = 4'd3;
    #1 chk("rsv3_ready", rsv_ready, 1'b1);
    tick(); tick(); idle();
    wen_e = 1'b1; dst_e = 4'd3; val_e = 64'd77;
    wen_m = 1'b1; dst_m = 4'd3; val_m = 64'd99;
    tick(); idle(); src_a = 4'd3;
    #1 chk("prio_val_a", val_a, 64'd99);
    chk("prio_busy_a", busy_a, 1'b0);
    chk("prio_wb_err", wb_err, 1'b0);

    // Two reservations, releases one by one
    rsv_valid = 1'b1; rsv_id = 4'd2;
    tick(); tick(); idle();
    wen_e = 1'b1; dst_e = 4'd2; val_e = 64'd11;
    tick(); idle(); src_a = 4'd2;
    #1 chk("sb_busy_one_left", busy_a, 1'b1);
    wen_e = 1'b1; dst_e = 4'd2; val_e = 64'd12;
    tick(); idle(); src_a = 4'd2;
    #1 chk("sb_busy_drained", busy_a, 1'b0);

    // RNONE reads/writes/reservations are inert
    snap = reg_dump;
    src_a = 4'd15; wen_e = 1'b1; dst_e = 4'd15; val_e = 64'd5;
    rsv_valid = 1'b1; rsv_id = 4'd15;
    #1 chk("rnone_val_a", val_a, 64'd0);
    chk("rnone_busy_a", busy_a, 1'b0);
    chk("rnone_rsv_ready", rsv_ready, 1'b0);
    tick(); idle();
    #1 checks++;
    if (reg_dump !== snap) begin
      errors++;
      $display("FAIL rnone_dump got %0h want %0h", reg_dump, snap);
    end
    chk("rnone_wb_err", wb_err, 1'b0);

    // Release with nothing pending
    wen_e = 1'b1; dst_e = 4'd2; val_e = 64'd13;
    tick(); idle(); src_a = 4'd2;
    #1 chk("uf_wb_err", wb_err, 1'b1);
    chk("uf_busy_a", busy_a, 1'b0);
    chk("uf_val_a", val_a, 64'd13);

    // Saturation of a 2-bit counter
    rsv_valid = 1'b1; rsv_id = 4'd5;
    for (int k = 0; k < 4; k++) begin
      #1 chk("sat_ready", rsv_ready, (k < 3) ? 1'b1 : 1'b0);
      tick();
    end
    wen_e = 1'b1; dst_e = 4'd5; val_e = 64'd55;
    #1 chk("sat_full_rel_ready", rsv_ready, 1'b0);
    tick();
    #1 chk("sat_rsv_rel_ready", rsv_ready, 1'b1);
    tick(); wen_e = 1'b0;
    #1 chk("sat_after_pair_ready", rsv_ready, 1'b1);
    tick();
    #1 chk("sat_refull_ready", rsv_ready, 1'b0);
    idle();

    // Writeback into a pending consumer read
    rsv_valid = 1'b1; rsv_id = 4'd1;
    tick(); idle();
    wen_e = 1'b1; dst_e = 4'd1; val_e = 64'd5;
    tick(); idle();
    rsv_valid = 1'b1; rsv_id = 4'd1;
    tick(); idle();
    wen_e = 1'b1; dst_e = 4'd1; val_e = 64'd42; src_a = 4'd1;
`ifdef REGFILE_BYPASS_EN
    #1 chk("byp_val_a", val_a, 64'd42);
    chk("byp_busy_a", busy_a, 1'b0);
`else
    #1 chk("nobyp_val_a", val_a, 64'd5);
    chk("nobyp_busy_a", busy_a, 1'b1);
`endif
    tick(); idle(); src_a = 4'd1;
    #1 chk("wb_next_val_a", val_a, 64'd42);
    chk("wb_next_busy_a", busy_a, 1'b0);

    // Reset mid-flight drops reservations and state
    rsv_valid = 1'b1; rsv_id = 4'd6;
    tick(); idle(); src_a = 4'd6;
    #1 chk("mid_busy_before", busy_a, 1'b1);
    reset_n = 1'b0;
    #1 chk("mid_busy_reset", busy_a, 1'b0);
    chk("mid_wb_err_reset", wb_err, 1'b0);
    chk("mid_reg3_reset", reg_dump[3*DW +: DW], 64'd0);
    tick();
    reset_n = 1'b1;
    tick(); tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
